// File: rtl/ctrl_redirect_unit.sv
// Writeback-side redirect controller: registers resolved control instructions, issues
// CTI-queue updates and sequences one oldest-first fetch redirect (with optional icache flush).
module ctrl_redirect_unit #(
  parameter int PC_W  = 64,
  parameter int SEQ_W = 32,
  parameter int AL_W  = 7,
  parameter int CTI_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_valid_i,
  input  logic [SEQ_W-1:0] wb_seqNo_i,
  input  logic [AL_W-1:0]  wb_alID_i,
  input  logic [CTI_W-1:0] wb_ctiID_i,
  input  logic             wb_mispred_i,
  input  logic [PC_W-1:0]  wb_nextPC_i,
  input  logic             wb_dir_i,
  input  logic             wb_icFlush_i,
  input  logic             squash_i,
  input  logic             redir_ready_i,
  output logic             redir_valid_o,
  output logic [PC_W-1:0]  redir_pc_o,
  output logic [AL_W-1:0]  redir_alID_o,
  output logic [CTI_W-1:0] redir_ctiID_o,
  output logic             ctiq_upd_o,
  output logic [CTI_W-1:0] ctiq_id_o,
  output logic             ctiq_dir_o,
  output logic [PC_W-1:0]  ctiq_tgt_o,
  output logic             ic_flush_req_o,
  input  logic             ic_flush_ack_i,
  output logic [15:0]      drop_cnt_o
);

  // state | meaning
  // IDLE  | nothing held
  // FLUSH | redirect held, waiting for icache flush acknowledge
  // REDIR | redirect presented to fetch, waiting for ready
  typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

  state_t           state;
  logic [SEQ_W-1:0] held_seq;
  logic [SEQ_W-1:0] wb_minus_held;
  logic [SEQ_W-1:0] held_minus_wb;
  logic             held;
  logic             wb_older;
  logic             wb_younger;
  logic             wb_mis;
  logic             take_new;
  logic             drop_new;
  logic             start_new;

  // Sequence numbers wrap, so age is the sign of the modular difference.
  assign held          = (state != IDLE);
  assign wb_minus_held = wb_seqNo_i - held_seq;
  assign held_minus_wb = held_seq - wb_seqNo_i;
  assign wb_older      = wb_minus_held[SEQ_W-1];
  assign wb_younger    = held_minus_wb[SEQ_W-1];
  assign wb_mis        = wb_valid_i & wb_mispred_i;
  assign take_new      = held & wb_mis & wb_older;
  assign drop_new      = held & wb_mis & ~wb_older;
  assign start_new     = (state == IDLE) & wb_valid_i & (wb_mispred_i | wb_icFlush_i);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      held_seq       <= '0;
      redir_valid_o  <= 1'b0;
      redir_pc_o     <= '0;
      redir_alID_o   <= '0;
      redir_ctiID_o  <= '0;
      ctiq_upd_o     <= 1'b0;
      ctiq_id_o      <= '0;
      ctiq_dir_o     <= 1'b0;
      ctiq_tgt_o     <= '0;
      ic_flush_req_o <= 1'b0;
      drop_cnt_o     <= '0;
    end else if (squash_i) begin
      state          <= IDLE;
      held_seq       <= '0;
      redir_valid_o  <= 1'b0;
      redir_pc_o     <= '0;
      redir_alID_o   <= '0;
      redir_ctiID_o  <= '0;
      ctiq_upd_o     <= 1'b0;
      ic_flush_req_o <= 1'b0;
    end else begin
      ctiq_upd_o <= 1'b0;
      if (wb_valid_i && (!held || !wb_younger)) begin
        ctiq_upd_o <= 1'b1;
        ctiq_id_o  <= wb_ctiID_i;
        ctiq_dir_o <= wb_dir_i;
        ctiq_tgt_o <= wb_nextPC_i;
      end

      if (drop_new && drop_cnt_o != 16'hFFFF)
        drop_cnt_o <= drop_cnt_o + 16'd1;

      if (start_new || take_new) begin
        held_seq      <= wb_seqNo_i;
        redir_pc_o    <= wb_nextPC_i;
        redir_alID_o  <= wb_alID_i;
        redir_ctiID_o <= wb_ctiID_i;
      end

      case (state)
        IDLE: begin
          if (start_new) begin
            if (wb_icFlush_i) begin
              state          <= FLUSH;
              ic_flush_req_o <= 1'b1;
              redir_valid_o  <= 1'b0;
            end else begin
              state          <= REDIR;
              ic_flush_req_o <= 1'b0;
              redir_valid_o  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (ic_flush_ack_i) begin
            state          <= REDIR;
            ic_flush_req_o <= 1'b0;
            redir_valid_o  <= 1'b1;
          end
        end
        REDIR: begin
          // An older replacement outranks a same-cycle accept of the stale target.
          if (take_new && wb_icFlush_i) begin
            state          <= FLUSH;
            ic_flush_req_o <= 1'b1;
            redir_valid_o  <= 1'b0;
          end else if (redir_ready_i && !take_new) begin
            state          <= IDLE;
            ic_flush_req_o <= 1'b0;
            redir_valid_o  <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          ic_flush_req_o <= 1'b0;
          redir_valid_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
